sdram_host_bridge: RTL and testbench

SDRAM_HOST_BRIDGE -- requirements
Module: sdram_host_bridge

---
 rtl/sdram_host_bridge.sv | 173 +++++++++++++++++
 tb/tb_sdram_host_bridge.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_host_bridge.sv
// sdram_host_bridge: queues host read/write requests in a small FIFO and
// hands them one at a time to an SDRAM controller (enable/busy handshake).
// Optional watchdog abort: define SDRAM_REQ_TIMEOUT_EN to enable it.
module sdram_host_bridge #(
  parameter int HADDR_WIDTH    = 24,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [HADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]            req_wdata,
  input  logic [1:0]             req_mask,
  output logic                   rsp_valid,
  output logic [15:0]            rsp_rdata,
  output logic                   rsp_err,
  output logic [HADDR_WIDTH-1:0] host_addr,
  output logic [15:0]            wr_data,
  output logic                   wr_enable,
  output logic                   wr_mask_low,
  output logic                   wr_mask_high,
  output logic                   rd_enable,
  input  logic [15:0]            rd_data,
  input  logic                   rd_ready,
  input  logic                   busy
);

  localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int ENTRY_W = 1 + HADDR_WIDTH + 16 + 2;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_RD, S_WAIT_WR} state_t;

  state_t                   r_state;
  state_t                   w_state_next;
  logic [ENTRY_W-1:0]       r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [PTR_W:0]           r_count;
  logic                     r_ready_en;
  logic                     r_hold_we;
  logic [HADDR_WIDTH-1:0]   r_hold_addr;
  logic [15:0]              r_hold_wdata;
  logic [1:0]               r_hold_mask;
  logic                     r_rsp_valid;
  logic [15:0]              r_rsp_rdata;
  logic                     w_full;
  logic                     w_empty;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_timeout;
  logic                     w_rd_en;
  logic                     w_wr_en;
  logic                     w_err;

  assign w_full  = (r_count == DEPTH_C);
  assign w_empty = (r_count == '0);
  // r_ready_en keeps req_ready low while reset is held and for no longer.
  assign req_ready = r_ready_en && !w_full;
  assign w_push    = req_valid && req_ready;
  assign w_pop     = (r_state == S_IDLE) && !w_empty;

  // Request storage has no reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo_mem[r_wr_ptr] <= {req_we, req_addr, req_wdata, req_mask};
  end

  // FIFO pointers and occupancy; pointers wrap naturally (depth is a power of 2).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_ready_en <= 1'b0;
    end else begin
      r_ready_en <= 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Hold registers: the popped request drives the controller until back in IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hold_we    <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
      r_hold_mask  <= '0;
    end else if (w_pop) begin
      {r_hold_we, r_hold_addr, r_hold_wdata, r_hold_mask} <= r_fifo_mem[r_rd_ptr];
    end
  end

`ifdef SDRAM_REQ_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wd_cnt;

  // Watchdog: restarts on each issue, counts every non-IDLE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_wd_cnt <= '0;
    else if (w_pop)              r_wd_cnt <= '0;
    else if (r_state != S_IDLE)  r_wd_cnt <= r_wd_cnt + CNT_W'(1);
  end

  assign w_timeout = (r_state != S_IDLE) && (r_wd_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  assign w_timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic; the enable is held in ISSUE until busy confirms acceptance
  // so a request offered during a controller refresh is not lost.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (!w_empty) w_state_next = S_ISSUE;
      S_ISSUE:   if (w_timeout) w_state_next = S_IDLE;
                 else if (busy) w_state_next = r_hold_we ? S_WAIT_WR : S_WAIT_RD;
      S_WAIT_RD: if (w_timeout || rd_ready) w_state_next = S_IDLE;
      S_WAIT_WR: if (w_timeout || !busy) w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
  end

  // Output decode: enables only in ISSUE and mutually exclusive by r_hold_we.
  always_comb begin
    w_rd_en = 1'b0;
    w_wr_en = 1'b0;
    w_err   = w_timeout;
    if (r_state == S_ISSUE && !w_timeout) begin
      w_rd_en = !r_hold_we;
      w_wr_en = r_hold_we;
    end
  end

  // Read response: capture data on rd_ready, strobe rsp_valid one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (r_state == S_WAIT_RD && rd_ready && !w_timeout) begin
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= rd_data;
      end
    end
  end

  assign rd_enable    = w_rd_en;
  assign wr_enable    = w_wr_en;
  assign rsp_err      = w_err;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_rdata    = r_rsp_rdata;
  assign host_addr    = r_hold_addr;
  assign wr_data      = r_hold_wdata;
  assign wr_mask_low  = r_hold_we & r_hold_mask[0];
  assign wr_mask_high = r_hold_we & r_hold_mask[1];

endmodule

// File: tb/tb_sdram_host_bridge.sv
// Directed testbench for sdram_host_bridge. Build with SDRAM_REQ_TIMEOUT_EN
// defined to exercise the watchdog path instead of the indefinite-wait path.
module tb_sdram_host_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [23:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_mask = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_err;
  logic [23:0] host_addr;
  logic [15:0] wr_data;
  logic        wr_enable;
  logic        wr_mask_low;
  logic        wr_mask_high;
  logic        rd_enable;
  logic [15:0] rd_data = '0;
  logic        rd_ready = 1'b0;
  logic        busy = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // bench-side activity monitor
  int          rsp_cnt = 0;
  int          err_cnt = 0;
  int          both_cnt = 0;
  logic        prev_en = 1'b0;
  logic [23:0] issued_q[$];

  sdram_host_bridge dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .host_addr(host_addr), .wr_data(wr_data), .wr_enable(wr_enable),
    .wr_mask_low(wr_mask_low), .wr_mask_high(wr_mask_high),
    .rd_enable(rd_enable), .rd_data(rd_data), .rd_ready(rd_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Count responses, aborts, and new issues (rising edge of either enable).
  always @(negedge clk) begin
    if (rst) begin
      prev_en = 1'b0;
    end else begin
      if ((rd_enable || wr_enable) && !prev_en) issued_q.push_back(host_addr);
      prev_en = rd_enable || wr_enable;
      if (rd_enable && wr_enable) both_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (rsp_err) err_cnt++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one request for one cycle (assumes the FIFO has room).
  task automatic send(input logic we, input logic [23:0] addr, input logic [15:0] wd,
                      input logic [1:0] mask);
    check_val("send_ready", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_mask = mask;
    tick;
    req_valid = 1'b0;
  endtask

  // Simple reactive controller: accept an enable, stay busy two cycles,
  // then finish (read completions return rd_data=0).
  task automatic serve(input int n);
    int cnt = 0;
    for (int i = 0; i < n; i++) begin
      rd_ready = 1'b0;
      if (busy) begin
        if (cnt == 0) begin
          busy = 1'b0;
          rd_ready = 1'b1;
          rd_data = 16'h0;
        end else cnt--;
      end else if (rd_enable || wr_enable) begin
        busy = 1'b1;
        cnt = 1;
      end
      tick;
    end
    rd_ready = 1'b0;
    busy = 1'b0;
  endtask

  initial begin
    int base_rsp;
    int base_iss;
    int idx;
    int cyc;
    logic acc;
    int acc_cyc[6];
    int exp_cyc[6];
    logic [23:0] exp_addr[6];

    // ---------------- reset state ----------------
    tick; tick;
    check_val("rst_req_ready", {31'd0, req_ready}, 32'd0);
    check_val("rst_enables", {30'd0, rd_enable, wr_enable}, 32'd0);
    check_val("rst_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check_val("rst_host_addr", {8'd0, host_addr}, 32'd0);
    rst = 1'b0;
    tick;
    check_val("post_rst_ready", {31'd0, req_ready}, 32'd1);

    // ---------------- single write ----------------
    base_rsp = rsp_cnt;
    send(1'b1, 24'h012345, 16'hA5A5, 2'b00);                 // now cycle 1
    check_val("wr_c1_enable", {31'd0, wr_enable}, 32'd0);
    tick;                                                    // cycle 2
    check_val("wr_c2_enable", {31'd0, wr_enable}, 32'd1);
    check_val("wr_c2_rd_en", {31'd0, rd_enable}, 32'd0);
    check_val("wr_c2_addr", {8'd0, host_addr}, 32'h012345);
    check_val("wr_c2_data", {16'd0, wr_data}, 32'hA5A5);
    check_val("wr_c2_masks", {30'd0, wr_mask_high, wr_mask_low}, 32'd0);
    tick;                                                    // cycle 3
    check_val("wr_c3_enable", {31'd0, wr_enable}, 32'd1);
    busy = 1'b1;
    tick;                                                    // cycle 4
    check_val("wr_c4_enable", {31'd0, wr_enable}, 32'd0);
    check_val("wr_c4_addr", {8'd0, host_addr}, 32'h012345);
    tick;                                                    // cycle 5
    check_val("wr_c5_addr", {8'd0, host_addr}, 32'h012345);
    busy = 1'b0;
    tick; tick;
    check_val("wr_no_rsp", rsp_cnt - base_rsp, 32'd0);

    // ---------------- single read ----------------
    base_rsp = rsp_cnt;
    send(1'b0, 24'h0ABCDE, 16'h0000, 2'b11);                 // cycle 1
    tick;                                                    // cycle 2
    check_val("rd_c2_enable", {31'd0, rd_enable}, 32'd1);
    check_val("rd_c2_wr_en", {31'd0, wr_enable}, 32'd0);
    check_val("rd_c2_masks", {30'd0, wr_mask_high, wr_mask_low}, 32'd0);
    check_val("rd_c2_addr", {8'd0, host_addr}, 32'h0ABCDE);
    busy = 1'b1;
    tick;                                                    // cycle 3
    check_val("rd_c3_enable", {31'd0, rd_enable}, 32'd0);
    tick;                                                    // cycle 4
    rd_ready = 1'b1; rd_data = 16'h5A5A; busy = 1'b0;
    tick;                                                    // cycle 5
    rd_ready = 1'b0;
    check_val("rd_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check_val("rd_rsp_rdata", {16'd0, rsp_rdata}, 32'h5A5A);
    tick;
    check_val("rd_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    check_val("rd_rsp_count", rsp_cnt - base_rsp, 32'd1);

    // ---------------- FIFO fill with busy held high ----------------
    issued_q.delete();
    exp_cyc = '{0, 1, 2, 3, 4, 10};
    for (int i = 0; i < 6; i++) exp_addr[i] = 24'h100000 + 24'(i);
    busy = 1'b1;
    idx = 0;
    cyc = 0;
    while (idx < 6 && cyc < 40) begin
      if (cyc == 8) busy = 1'b0;
      req_valid = 1'b1; req_we = 1'b1; req_addr = exp_addr[idx];
      req_wdata = 16'h1000 + 16'(idx); req_mask = 2'b00;
      @(negedge clk);
      acc = req_ready;
      if (cyc == 5 || cyc == 7 || cyc == 9) check_val($sformatf("fill_ready_c%0d", cyc), {31'd0, req_ready}, 32'd0);
      tick;
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
      end
      cyc++;
    end
    req_valid = 1'b0;
    check_val("fill_accepted", idx, 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < idx) check_val($sformatf("fill_acc_cycle%0d", i), acc_cyc[i], exp_cyc[i]);
    serve(80);
    check_val("fill_issued", issued_q.size(), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < issued_q.size()) check_val($sformatf("fill_order%0d", i), {8'd0, issued_q[i]}, {8'd0, exp_addr[i]});

    // ---------------- refresh collision ----------------
    base_iss = issued_q.size();
    busy = 1'b0;
    send(1'b1, 24'h222222, 16'h1234, 2'b01);                 // cycle 1
    tick;                                                    // cycle 2
    for (int i = 0; i < 6; i++) begin
      check_val($sformatf("refresh_en%0d", i), {31'd0, wr_enable}, 32'd1);
      tick;
    end
    busy = 1'b1;                                             // cycle 8
    tick;
    check_val("refresh_en_drop", {31'd0, wr_enable}, 32'd0);
    busy = 1'b0;
    tick; tick;
    check_val("refresh_one_issue", issued_q.size() - base_iss, 32'd1);

    // ---------------- reset mid-read ----------------
    base_rsp = rsp_cnt;
    send(1'b0, 24'h033333, 16'h0000, 2'b00);                 // cycle 1
    send(1'b1, 24'h044444, 16'h7777, 2'b10);                 // cycle 2 (queued)
    busy = 1'b1;
    tick;                                                    // cycle 3, WAIT_RD
    check_val("mid_addr", {8'd0, host_addr}, 32'h033333);
    #2 rst = 1'b1;
    #1;
    check_val("async_req_ready", {31'd0, req_ready}, 32'd0);
    check_val("async_enables", {30'd0, rd_enable, wr_enable}, 32'd0);
    check_val("async_rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check_val("async_rdata", {16'd0, rsp_rdata}, 32'd0);
    check_val("async_host_addr", {8'd0, host_addr}, 32'd0);
    check_val("async_wr_data", {16'd0, wr_data}, 32'd0);
    check_val("async_masks", {30'd0, wr_mask_high, wr_mask_low}, 32'd0);
    busy = 1'b0;
    tick;
    rst = 1'b0;
    base_iss = issued_q.size();
    tick;
    check_val("rel_req_ready", {31'd0, req_ready}, 32'd1);
    rd_ready = 1'b1; rd_data = 16'hBEEF;
    tick;
    rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick;
    check_val("rel_no_rsp", rsp_cnt - base_rsp, 32'd0);
    check_val("rel_fifo_empty", issued_q.size() - base_iss, 32'd0);

    // ---------------- watchdog ----------------
`ifdef SDRAM_REQ_TIMEOUT_EN
    begin
      int en_cycles;
      int err_at;
      int base_err;
      base_err = err_cnt;
      base_rsp = rsp_cnt;
      busy = 1'b0;
      send(1'b0, 24'h055555, 16'h0000, 2'b00);               // cycle 1
      send(1'b1, 24'h066666, 16'h4321, 2'b00);               // cycle 2
      cyc = 2; en_cycles = 0; err_at = -1;
      while (cyc < 200 && err_at < 0) begin
        if (rd_enable) en_cycles++;
        if (rsp_err) err_at = cyc;
        tick;
        cyc++;
      end
      check_val("wd_err_cycle", err_at, 32'd66);
      check_val("wd_en_cycles", en_cycles, 32'd64);
      tick;                                                  // cycle 68
      check_val("wd_next_issue", {31'd0, wr_enable}, 32'd1);
      check_val("wd_next_addr", {8'd0, host_addr}, 32'h066666);
      serve(20);
      check_val("wd_err_once", err_cnt - base_err, 32'd1);
      check_val("wd_no_rsp", rsp_cnt - base_rsp, 32'd0);
    end
`else
    busy = 1'b0;
    send(1'b0, 24'h055555, 16'h0000, 2'b00);
    tick;
    for (int i = 0; i < 100; i++) tick;
    check_val("nowd_still_issue", {31'd0, rd_enable}, 32'd1);
    check_val("nowd_no_err", err_cnt, 32'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
`endif

    check_val("en_never_both", both_cnt, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
